axi_rr_arbiter: RTL and testbench
=================================

AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; STRB_W, default DATA_W/8, write-strobe width.
REQ-002 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 SHALL have, per master mN (N=0 IFU, N=1 LSU), read-address ports: mN_arvalid in 1; mN_araddr in ADDR_W; mN_arready out 1.
REQ-005 SHALL have, per master mN, read-data ports: mN_rready in 1; mN_rvalid out 1; mN_rresp out 2; mN_rdata out DATA_W.
REQ-006 SHALL have, per master mN, write ports: mN_awvalid, mN_wvalid, mN_bready in 1; mN_awaddr in ADDR_W; mN_wdata in DATA_W; mN_wstrb in STRB_W; mN_awready, mN_wready, mN_bvalid out 1; mN_bresp out 2.
REQ-007 SHALL have slave-side ports s_*: the same AR/R/AW/W/B signals with directions mirrored (valid/addr/data/strb/ready-for-response out; ready/valid-for-response/resp/data in).

Function
REQ-008 SHALL arbitrate read (AR+R) and write (AW+W+B) paths independently; one read and one write transaction SHALL be able to be in flight at once, from the same or different masters.
REQ-009 Each path SHALL use an FSM with states IDLE, GNT0, GNT1.
REQ-010 IDLE: read request of mN = mN_arvalid; write request of mN = mN_awvalid | mN_wvalid.
REQ-011 IDLE with a single requester SHALL move to that master's GNT state on the next edge.
REQ-012 IDLE with both requesting SHALL grant the master not recorded in that path's last-grant register (round-robin); the last-grant register SHALL update on entering GNTx.
REQ-013 GNTx SHALL hold until response handshake (read: s_rvalid & s_rready; write: s_bvalid & s_bready), then return to IDLE; one idle cycle minimum between grants.
REQ-014 In GNTx, s_* request signals SHALL equal master x's, and master x's ready/response outputs SHALL equal s_*, combinationally (zero added latency).
REQ-015 The non-granted master, and both masters in IDLE, SHALL see all ready/valid/resp/data outputs = 0; in IDLE all s_* outputs SHALL be 0.
REQ-016 Request-to-slave latency: request first high in cycle T -> s_arvalid/s_awvalid high in cycle T+1.
REQ-017 A master that drops its request before the grant edge SHALL not be granted; after the grant, the arbiter SHALL not abort or re-arbitrate until the response handshake.
REQ-018 AW and W handshakes within GNTx SHALL be allowed in either order or the same cycle; the arbiter SHALL not check them, only B.
REQ-019 Error responses (rresp/bresp != 0) SHALL pass through unchanged and end the grant like OKAY.
REQ-020 Invalid FSM encodings SHALL return to IDLE on the next edge.

Reset
REQ-021 On rst both FSMs SHALL go to IDLE and both last-grant registers to master 1 (master 0 wins the first tie).
REQ-022 During and after reset all outputs SHALL be 0 until a grant.
REQ-023 rst mid-transaction SHALL abandon the transaction immediately; no response SHALL be forwarded after it.

Structure
REQ-024 FSM state encodings (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10) and response codes (OKAY=2'b00, SLVERR=2'b10) SHALL be in the shared AXI package.
REQ-025 One sub-module, rr_grant2 (2-requester round-robin FSM with last-grant register), SHALL be instantiated once for read and once for write.
REQ-026 All data muxing SHALL be combinational from the registered state; no data registers.

Verification
REQ-027 Only m0_arvalid, araddr 0x8000_0000; slave returns rdata 0xDEAD_BEEF after 3 cycles -> m0_rdata=0xDEADBEEF, m1 outputs 0, FSM IDLE the cycle after the handshake.
REQ-028 m0 and m1 arvalid together, back-to-back 4 times -> grant order m0,m1,m0,m1; each transaction ends in the same master's R handshake.
REQ-029 m1 writes 0x1234_5678 to 0xA000_03F8, wstrb 0xF, while m0 reads 0x8000_0010 -> both proceed concurrently; s_awaddr=0xA00003F8, m0 read data unaffected.
REQ-030 Slave returns bresp=2'b10 to m1 -> m1_bresp=2'b10, grant released, next m0 write granted.
REQ-031 rst asserted for 1 cycle while GNT0 read awaiting rvalid -> all outputs 0 next cycle; a late s_rvalid is not forwarded; next tie goes to m0.
REQ-032 m1 raises wvalid two cycles before awvalid -> granted on wvalid; s_wvalid forwarded at T+1, s_awvalid follows the master's timing.

Source files
------------

// File: rtl/axi_rr_arbiter_pkg.sv
// Shared AXI arbiter definitions: grant FSM encodings, response codes and the
// round-robin pick helper used by both the read and write paths.
package axi_rr_arbiter_pkg;

  localparam int unsigned ST_W   = 2;
  localparam int unsigned RESP_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
  localparam logic [ST_W-1:0] ST_GNT0 = 2'b01;
  localparam logic [ST_W-1:0] ST_GNT1 = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  // Returns 1 when master 1 should win: sole requester, or a tie after master 0 last won.
  function automatic logic rr_pick1(input logic [1:0] req, input logic last);
    return (req == 2'b10) | ((req == 2'b11) & ~last);
  endfunction

endpackage

// File: rtl/axi_rr_arbiter_if.sv
// AXI-lite style link (AR/R/AW/W/B) shared by the two masters and the slave port.
interface axi_rr_arbiter_if
  import axi_rr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [RESP_W-1:0] rresp;
  logic [DATA_W-1:0] rdata;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [RESP_W-1:0] bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rresp, rdata, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rresp, rdata, awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/axi_rr_arbiter_rr_grant2.sv
// Two-requester round-robin grant FSM; holds a grant until the response
// handshake and remembers the last winner for tie-breaking.
module rr_grant2
  import axi_rr_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      i_req,
  input  logic            i_done,
  output logic [ST_W-1:0] o_state
);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;
  logic            r_last;
  logic            w_last_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Unknown encodings fall through to the IDLE default.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          if (rr_pick1(i_req, r_last)) begin
            w_state_nxt = ST_GNT1;
            w_last_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_GNT0;
            w_last_nxt  = 1'b0;
          end
        end
      end
      ST_GNT0: w_state_nxt = i_done ? ST_IDLE : ST_GNT0;
      ST_GNT1: w_state_nxt = i_done ? ST_IDLE : ST_GNT1;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/axi_rr_arbiter.sv
// Two-master (IFU=m0, LSU=m1) to one-slave AXI-lite arbiter with independent
// round-robin read and write paths and purely combinational forwarding.
module axi_rr_arbiter
  import axi_rr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic             clk,
  input  logic             rst,
  axi_rr_arbiter_if.slave  m0,
  axi_rr_arbiter_if.slave  m1,
  axi_rr_arbiter_if.master s
);

  logic [ST_W-1:0] w_rd_state;
  logic [ST_W-1:0] w_wr_state;
  logic            w_rd_g0;
  logic            w_rd_g1;
  logic            w_wr_g0;
  logic            w_wr_g1;
  logic [1:0]      w_rd_req;
  logic [1:0]      w_wr_req;
  logic            w_rd_done;
  logic            w_wr_done;

  assign w_rd_req  = {m1.arvalid, m0.arvalid};
  assign w_wr_req  = {m1.awvalid | m1.wvalid, m0.awvalid | m0.wvalid};
  assign w_rd_done = s.rvalid & s.rready;
  assign w_wr_done = s.bvalid & s.bready;

  rr_grant2 u_rd_gnt (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_rd_req),
    .i_done  (w_rd_done),
    .o_state (w_rd_state)
  );

  rr_grant2 u_wr_gnt (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_wr_req),
    .i_done  (w_wr_done),
    .o_state (w_wr_state)
  );

  // Grants are masked by rst so a reset cycle drops the transaction at once.
  assign w_rd_g0 = (w_rd_state == ST_GNT0) & ~rst;
  assign w_rd_g1 = (w_rd_state == ST_GNT1) & ~rst;
  assign w_wr_g0 = (w_wr_state == ST_GNT0) & ~rst;
  assign w_wr_g1 = (w_wr_state == ST_GNT1) & ~rst;

  assign s.arvalid = (w_rd_g0 & m0.arvalid) | (w_rd_g1 & m1.arvalid);
  assign s.araddr  = w_rd_g0 ? m0.araddr : (w_rd_g1 ? m1.araddr : ADDR_W'(0));
  assign s.rready  = (w_rd_g0 & m0.rready) | (w_rd_g1 & m1.rready);

  assign m0.arready = w_rd_g0 & s.arready;
  assign m0.rvalid  = w_rd_g0 & s.rvalid;
  assign m0.rresp   = w_rd_g0 ? s.rresp : RESP_OKAY;
  assign m0.rdata   = w_rd_g0 ? s.rdata : DATA_W'(0);
  assign m1.arready = w_rd_g1 & s.arready;
  assign m1.rvalid  = w_rd_g1 & s.rvalid;
  assign m1.rresp   = w_rd_g1 ? s.rresp : RESP_OKAY;
  assign m1.rdata   = w_rd_g1 ? s.rdata : DATA_W'(0);

  // AW and W pass independently; only the B handshake ends the write grant.
  assign s.awvalid = (w_wr_g0 & m0.awvalid) | (w_wr_g1 & m1.awvalid);
  assign s.awaddr  = w_wr_g0 ? m0.awaddr : (w_wr_g1 ? m1.awaddr : ADDR_W'(0));
  assign s.wvalid  = (w_wr_g0 & m0.wvalid) | (w_wr_g1 & m1.wvalid);
  assign s.wdata   = w_wr_g0 ? m0.wdata : (w_wr_g1 ? m1.wdata : DATA_W'(0));
  assign s.wstrb   = w_wr_g0 ? m0.wstrb : (w_wr_g1 ? m1.wstrb : STRB_W'(0));
  assign s.bready  = (w_wr_g0 & m0.bready) | (w_wr_g1 & m1.bready);

  assign m0.awready = w_wr_g0 & s.awready;
  assign m0.wready  = w_wr_g0 & s.wready;
  assign m0.bvalid  = w_wr_g0 & s.bvalid;
  assign m0.bresp   = w_wr_g0 ? s.bresp : RESP_OKAY;
  assign m1.awready = w_wr_g1 & s.awready;
  assign m1.wready  = w_wr_g1 & s.wready;
  assign m1.bvalid  = w_wr_g1 & s.bvalid;
  assign m1.bresp   = w_wr_g1 ? s.bresp : RESP_OKAY;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Randomized bench for axi_rr_arbiter: random masters and slave, an ownership
// model per path, and end-to-end data/response scoreboarding.
module tb_axi_rr_arbiter;
  import axi_rr_arbiter_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int          NCYC   = 4000;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  axi_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) m0_if ();
  axi_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) m1_if ();
  axi_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) s_if ();

  axi_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  // Master-side drives
  logic        mar_v  [2];
  logic [31:0] mar_a  [2];
  logic        mr_rdy [2];
  logic        maw_v  [2];
  logic [31:0] maw_a  [2];
  logic        mw_v   [2];
  logic [31:0] mw_d   [2];
  logic [3:0]  mw_s   [2];
  logic        mb_rdy [2];
  // Slave-side drives
  logic        s_arrdy, s_rv, s_awrdy, s_wrdy, s_bv;
  logic [1:0]  s_rresp, s_bresp;
  logic [31:0] s_rdata;

  assign m0_if.arvalid = mar_v[0];  assign m1_if.arvalid = mar_v[1];
  assign m0_if.araddr  = mar_a[0];  assign m1_if.araddr  = mar_a[1];
  assign m0_if.rready  = mr_rdy[0]; assign m1_if.rready  = mr_rdy[1];
  assign m0_if.awvalid = maw_v[0];  assign m1_if.awvalid = maw_v[1];
  assign m0_if.awaddr  = maw_a[0];  assign m1_if.awaddr  = maw_a[1];
  assign m0_if.wvalid  = mw_v[0];   assign m1_if.wvalid  = mw_v[1];
  assign m0_if.wdata   = mw_d[0];   assign m1_if.wdata   = mw_d[1];
  assign m0_if.wstrb   = mw_s[0];   assign m1_if.wstrb   = mw_s[1];
  assign m0_if.bready  = mb_rdy[0]; assign m1_if.bready  = mb_rdy[1];

  assign s_if.arready = s_arrdy;
  assign s_if.rvalid  = s_rv;
  assign s_if.rresp   = s_rresp;
  assign s_if.rdata   = s_rdata;
  assign s_if.awready = s_awrdy;
  assign s_if.wready  = s_wrdy;
  assign s_if.bvalid  = s_bv;
  assign s_if.bresp   = s_bresp;

  logic [1:0]  g_arrdy, g_rv, g_awrdy, g_wrdy, g_bv;
  logic [1:0]  g_rresp [2];
  logic [1:0]  g_bresp [2];
  logic [31:0] g_rdata [2];
  assign g_arrdy = {m1_if.arready, m0_if.arready};
  assign g_rv    = {m1_if.rvalid,  m0_if.rvalid};
  assign g_awrdy = {m1_if.awready, m0_if.awready};
  assign g_wrdy  = {m1_if.wready,  m0_if.wready};
  assign g_bv    = {m1_if.bvalid,  m0_if.bvalid};
  assign g_rresp[0] = m0_if.rresp; assign g_rresp[1] = m1_if.rresp;
  assign g_bresp[0] = m0_if.bresp; assign g_bresp[1] = m1_if.bresp;
  assign g_rdata[0] = m0_if.rdata; assign g_rdata[1] = m1_if.rdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave behaviour is a pure function of the address so masters can check end to end.
  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5EAD_BEEF;
  endfunction
  function automatic logic [1:0] rresp_of(input logic [31:0] a);
    return a[2] ? RESP_SLVERR : RESP_OKAY;
  endfunction
  function automatic logic [1:0] bresp_of(input logic [31:0] a);
    return a[3] ? RESP_SLVERR : RESP_OKAY;
  endfunction
  function automatic logic [31:0] wdata_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [3:0] wstrb_of(input logic [31:0] a);
    return a[7:4];
  endfunction
  function automatic logic [31:0] pick_addr();
    case ($urandom_range(3))
      0:       return 32'h8000_0000;
      1:       return 32'hA000_03F8;
      2:       return 32'h8000_0010;
      default: return $urandom() & 32'hFFFF_FFFC;
    endcase
  endfunction

  // Reference model: who owns each path (-1 = nobody) and who won last.
  int rd_own, rd_last, wr_own, wr_last, rd_ties, wr_ties;

  // Agent state
  int          mrd_st [2];
  logic [31:0] mrd_addr [2];
  int          mwr_st [2];
  logic [31:0] mwr_addr [2];
  logic        maw_done [2];
  logic        mw_done [2];
  int          maw_dly [2];
  int          mw_dly [2];
  int          rd_cnt [2];
  int          wr_cnt [2];
  int          srd_st, srd_dly, srd_zombie;
  logic [31:0] srd_addr;
  int          swr_st, swr_dly, swr_zombie;
  logic        sw_aw_got, sw_w_got;
  logic [31:0] sw_addr, sw_data;
  logic [3:0]  sw_strb;
  int          holdoff, n_midrst;
  logic        rst_pend;

  task automatic drive_cycle(input int cyc);
    logic do_rst;
    do_rst = (cyc < 3);
    if (cyc == 1500 || cyc == 3000) rst_pend = 1'b1;
    if (rst_pend && rd_own >= 0 && srd_st == 1) begin
      do_rst   = 1'b1;
      rst_pend = 1'b0;
      n_midrst++;
    end
    rst = do_rst;
    if (do_rst) begin
      for (int i = 0; i < 2; i++) begin
        mrd_st[i] = 0;
        mwr_st[i] = 0;
      end
      if (srd_st != 0 && srd_zombie == 0) srd_zombie = srd_dly + 3;
      if (swr_st != 0 && swr_zombie == 0) swr_zombie = swr_dly + 3;
      if (swr_st == 0) begin
        sw_aw_got = 1'b0;
        sw_w_got  = 1'b0;
      end
      holdoff = 12;
    end else if (holdoff > 0) begin
      holdoff--;
    end

    for (int i = 0; i < 2; i++) begin
      if (!do_rst && holdoff == 0 && mrd_st[i] == 0 && $urandom_range(2) == 0) begin
        mrd_st[i]   = 1;
        mrd_addr[i] = pick_addr();
      end
      if (mrd_st[i] == 1 && rd_own != i && $urandom_range(15) == 0) mrd_st[i] = 0;
      mar_v[i]  = (mrd_st[i] == 1);
      mar_a[i]  = mar_v[i] ? mrd_addr[i] : $urandom();
      mr_rdy[i] = ($urandom_range(3) != 0);

      if (!do_rst && holdoff == 0 && mwr_st[i] == 0 && $urandom_range(2) == 0) begin
        mwr_st[i]   = 1;
        mwr_addr[i] = pick_addr();
        maw_done[i] = 1'b0;
        mw_done[i]  = 1'b0;
        maw_dly[i]  = $urandom_range(3);
        mw_dly[i]   = $urandom_range(3);
      end
      if (mwr_st[i] == 1 && wr_own != i && !maw_done[i] && !mw_done[i] && $urandom_range(15) == 0)
        mwr_st[i] = 0;
      maw_v[i] = (mwr_st[i] == 1) && !maw_done[i] && (maw_dly[i] == 0);
      mw_v[i]  = (mwr_st[i] == 1) && !mw_done[i] && (mw_dly[i] == 0);
      if (mwr_st[i] == 1 && maw_dly[i] > 0) maw_dly[i]--;
      if (mwr_st[i] == 1 && mw_dly[i] > 0) mw_dly[i]--;
      maw_a[i]  = maw_v[i] ? mwr_addr[i] : $urandom();
      mw_d[i]   = mw_v[i] ? wdata_of(mwr_addr[i]) : $urandom();
      mw_s[i]   = mw_v[i] ? wstrb_of(mwr_addr[i]) : 4'($urandom());
      mb_rdy[i] = ($urandom_range(3) != 0);
    end

    s_arrdy = (srd_st == 0 && srd_zombie == 0) ? 1'($urandom_range(1)) : 1'b0;
    s_rv    = (srd_st == 2);
    s_rdata = s_rv ? rdata_of(srd_addr) : $urandom();
    s_rresp = s_rv ? rresp_of(srd_addr) : 2'($urandom());
    s_awrdy = (swr_st == 0 && swr_zombie == 0 && !sw_aw_got) ? 1'($urandom_range(1)) : 1'b0;
    s_wrdy  = (swr_st == 0 && swr_zombie == 0 && !sw_w_got) ? 1'($urandom_range(1)) : 1'b0;
    s_bv    = (swr_st == 2);
    s_bresp = s_bv ? bresp_of(sw_addr) : 2'($urandom());
  endtask

  task automatic check_cycle();
    int ro, wo;
    logic [127:0] e;
    ro = rst ? -1 : rd_own;
    wo = rst ? -1 : wr_own;
    e = '0;
    if (ro >= 0) e = 128'({mar_v[ro], mar_a[ro], mr_rdy[ro]});
    check_eq("s_rd", 128'({s_if.arvalid, s_if.araddr, s_if.rready}), e);
    e = '0;
    if (wo >= 0) e = 128'({maw_v[wo], maw_a[wo], mw_v[wo], mw_d[wo], mw_s[wo], mb_rdy[wo]});
    check_eq("s_wr", 128'({s_if.awvalid, s_if.awaddr, s_if.wvalid, s_if.wdata, s_if.wstrb, s_if.bready}), e);
    for (int i = 0; i < 2; i++) begin
      e = (ro == i) ? 128'({s_arrdy, s_rv, s_rresp, s_rdata}) : 128'(0);
      check_eq($sformatf("m%0d_rd", i), 128'({g_arrdy[i], g_rv[i], g_rresp[i], g_rdata[i]}), e);
      e = (wo == i) ? 128'({s_awrdy, s_wrdy, s_bv, s_bresp}) : 128'(0);
      check_eq($sformatf("m%0d_wr", i), 128'({g_awrdy[i], g_wrdy[i], g_bv[i], g_bresp[i]}), e);
    end
  endtask

  task automatic observe_cycle();
    for (int i = 0; i < 2; i++) begin
      if (mar_v[i] && g_arrdy[i]) mrd_st[i] = 2;
      if (mrd_st[i] == 2 && g_rv[i] && mr_rdy[i]) begin
        check_eq($sformatf("m%0d_rdata", i), 128'(g_rdata[i]), 128'(rdata_of(mrd_addr[i])));
        check_eq($sformatf("m%0d_rresp", i), 128'(g_rresp[i]), 128'(rresp_of(mrd_addr[i])));
        rd_cnt[i]++;
        mrd_st[i] = 0;
      end
      if (maw_v[i] && g_awrdy[i]) maw_done[i] = 1'b1;
      if (mw_v[i] && g_wrdy[i]) mw_done[i] = 1'b1;
      if (mwr_st[i] == 1 && g_bv[i] && mb_rdy[i]) begin
        check_eq($sformatf("m%0d_bresp", i), 128'(g_bresp[i]), 128'(bresp_of(mwr_addr[i])));
        wr_cnt[i]++;
        mwr_st[i] = 0;
      end
    end

    if (srd_st == 0) begin
      if (s_if.arvalid && s_arrdy) begin
        srd_addr = s_if.araddr;
        srd_dly  = $urandom_range(3);
        srd_st   = 1;
      end
    end else if (srd_st == 1) begin
      if (srd_dly == 0) srd_st = 2;
      else srd_dly--;
    end else if (s_if.rready) begin
      srd_st = 0;
    end
    if (srd_zombie > 0) begin
      srd_zombie--;
      if (srd_zombie == 0) srd_st = 0;
    end

    if (swr_st == 0) begin
      if (s_if.awvalid && s_awrdy) begin
        sw_aw_got = 1'b1;
        sw_addr   = s_if.awaddr;
      end
      if (s_if.wvalid && s_wrdy) begin
        sw_w_got = 1'b1;
        sw_data  = s_if.wdata;
        sw_strb  = s_if.wstrb;
      end
      if (sw_aw_got && sw_w_got) begin
        check_eq("s_wdata", 128'(sw_data), 128'(wdata_of(sw_addr)));
        check_eq("s_wstrb", 128'(sw_strb), 128'(wstrb_of(sw_addr)));
        swr_st  = 1;
        swr_dly = $urandom_range(3);
      end
    end else if (swr_st == 1) begin
      if (swr_dly == 0) swr_st = 2;
      else swr_dly--;
    end else if (s_if.bready) begin
      swr_st    = 0;
      sw_aw_got = 1'b0;
      sw_w_got  = 1'b0;
    end
    if (swr_zombie > 0) begin
      swr_zombie--;
      if (swr_zombie == 0) begin
        swr_st    = 0;
        sw_aw_got = 1'b0;
        sw_w_got  = 1'b0;
      end
    end

    // Ownership model, driven only by what the bench itself put on the wires.
    if (rst) begin
      rd_own = -1; rd_last = 1;
      wr_own = -1; wr_last = 1;
    end else begin
      if (rd_own < 0) begin
        if (mar_v[0] && mar_v[1]) begin rd_own = 1 - rd_last; rd_ties++; end
        else if (mar_v[0]) rd_own = 0;
        else if (mar_v[1]) rd_own = 1;
        if (rd_own >= 0) rd_last = rd_own;
      end else if (s_rv && mr_rdy[rd_own]) begin
        rd_own = -1;
      end
      if (wr_own < 0) begin
        if ((maw_v[0] || mw_v[0]) && (maw_v[1] || mw_v[1])) begin wr_own = 1 - wr_last; wr_ties++; end
        else if (maw_v[0] || mw_v[0]) wr_own = 0;
        else if (maw_v[1] || mw_v[1]) wr_own = 1;
        if (wr_own >= 0) wr_last = wr_own;
      end else if (s_bv && mb_rdy[wr_own]) begin
        wr_own = -1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_own = -1; rd_last = 1; wr_own = -1; wr_last = 1;
    rd_ties = 0; wr_ties = 0; holdoff = 0; n_midrst = 0; rst_pend = 1'b0;
    srd_st = 0; srd_dly = 0; srd_zombie = 0; srd_addr = '0;
    swr_st = 0; swr_dly = 0; swr_zombie = 0;
    sw_aw_got = 1'b0; sw_w_got = 1'b0; sw_addr = '0; sw_data = '0; sw_strb = '0;
    for (int i = 0; i < 2; i++) begin
      mrd_st[i] = 0; mwr_st[i] = 0; rd_cnt[i] = 0; wr_cnt[i] = 0;
      mrd_addr[i] = '0; mwr_addr[i] = '0;
      maw_done[i] = 1'b0; mw_done[i] = 1'b0; maw_dly[i] = 0; mw_dly[i] = 0;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      drive_cycle(cyc);
      @(negedge clk);
      check_cycle();
      observe_cycle();
      @(posedge clk);
      #1;
    end

    check_eq("m0_reads_done",  128'(rd_cnt[0] > 20), 128'(1));
    check_eq("m1_reads_done",  128'(rd_cnt[1] > 20), 128'(1));
    check_eq("m0_writes_done", 128'(wr_cnt[0] > 20), 128'(1));
    check_eq("m1_writes_done", 128'(wr_cnt[1] > 20), 128'(1));
    check_eq("rd_ties_seen",   128'(rd_ties > 0), 128'(1));
    check_eq("wr_ties_seen",   128'(wr_ties > 0), 128'(1));
    check_eq("mid_txn_resets", 128'(n_midrst > 0), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
